// File: rtl/sequenceur_jeu.sv
// Game-flow controller for the three-column falling-brick game: gravity tick, active column, heights.
// Optional macro SEQ_SCORE_EN adds the 8-bit saturating clear counter on score (tied to 0 otherwise).
module sequenceur_jeu #(
  parameter int TICK_DIV = 10000,
  parameter int FAST_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       boutonTomber,
  input  logic       boutonGauche,
  input  logic       boutonDroite,
  input  logic       PlusGauche,
  input  logic       PlusCentre,
  input  logic       PlusDroite,
  input  logic       Aligne,
  input  logic       Perdu,
  output logic       pulse,
  output logic [1:0] col,
  output logic [2:0] hauteurGauche,
  output logic [2:0] hauteurCentre,
  output logic [2:0] hauteurDroite,
  output logic [2:0] etat,
  output logic [7:0] score
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    LAND  = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [15:0]     cnt_reg, cnt_next;
  logic            pulse_reg, pulse_next;
  logic [1:0]      col_reg, col_next;
  logic [2:0][2:0] haut_reg, haut_next;
  logic [2:0][2:0] haut_inc, haut_dec;
  logic            start_prev_reg, gauche_prev_reg, droite_prev_reg;

  logic        start_edge, gauche_edge, droite_edge;
  logic [2:0]  plus;
  logic [15:0] divisor;
  logic        terminal;

  assign start_edge  = start & ~start_prev_reg;
  assign gauche_edge = boutonGauche & ~gauche_prev_reg;
  assign droite_edge = boutonDroite & ~droite_prev_reg;
  assign plus        = {PlusDroite, PlusCentre, PlusGauche};

  // ">=" rather than "==" so a mid-count switch to fast mode fires immediately
  assign divisor  = boutonTomber ? 16'(FAST_DIV) : 16'(TICK_DIV);
  assign terminal = (cnt_reg >= (divisor - 16'd1));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_col
      assign haut_inc[gi] = (haut_reg[gi] == 3'd7) ? 3'd7 : haut_reg[gi] + 3'd1;
      assign haut_dec[gi] = (haut_reg[gi] == 3'd0) ? 3'd0 : haut_reg[gi] - 3'd1;
    end
  endgenerate

`ifdef SEQ_SCORE_EN
  logic [7:0] score_reg, score_next;
  assign score = score_reg;
`else
  assign score = 8'd0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    col_next   = col_reg;
    haut_next  = haut_reg;
`ifdef SEQ_SCORE_EN
    score_next = score_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = 16'd0;
        if (start_edge) state_next = SPAWN;
      end
      SPAWN: begin
        cnt_next = 16'd0;
        if (haut_reg[col_reg] == 3'd7) state_next = OVER;
        else                           state_next = FALL;
      end
      FALL: begin
        if (terminal) begin
          cnt_next   = 16'd0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
        if (gauche_edge && !droite_edge && col_reg != 2'd0) col_next = col_reg - 2'd1;
        if (droite_edge && !gauche_edge && col_reg < 2'd2)  col_next = col_reg + 2'd1;
        // Loss wins over a simultaneous landing; the tick never leaks past FALL
        if (Perdu) begin
          state_next = OVER;
          pulse_next = 1'b0;
        end else if (|plus) begin
          for (int i = 0; i < 3; i++)
            if (plus[i]) haut_next[i] = haut_inc[i];
          state_next = LAND;
          pulse_next = 1'b0;
        end
      end
      LAND: begin
        state_next = Aligne ? CLEAR : SPAWN;
      end
      CLEAR: begin
        haut_next = haut_dec;
`ifdef SEQ_SCORE_EN
        if (score_reg != 8'd255) score_next = score_reg + 8'd1;
`endif
        state_next = SPAWN;
      end
      OVER: begin
        if (start_edge) begin
          haut_next  = '0;
          col_next   = 2'd1;
`ifdef SEQ_SCORE_EN
          score_next = 8'd0;
`endif
          state_next = SPAWN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= 16'd0;
      pulse_reg       <= 1'b0;
      col_reg         <= 2'd1;
      haut_reg        <= '0;
      start_prev_reg  <= 1'b0;
      gauche_prev_reg <= 1'b0;
      droite_prev_reg <= 1'b0;
`ifdef SEQ_SCORE_EN
      score_reg       <= 8'd0;
`endif
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      pulse_reg       <= pulse_next;
      col_reg         <= col_next;
      haut_reg        <= haut_next;
      start_prev_reg  <= start;
      gauche_prev_reg <= boutonGauche;
      droite_prev_reg <= boutonDroite;
`ifdef SEQ_SCORE_EN
      score_reg       <= score_next;
`endif
    end
  end

  assign pulse         = pulse_reg;
  assign col           = col_reg;
  assign hauteurGauche = haut_reg[0];
  assign hauteurCentre = haut_reg[1];
  assign hauteurDroite = haut_reg[2];
  assign etat          = state_reg;

endmodule

// File: tb/tb_sequenceur_jeu.sv
// Directed bench for sequenceur_jeu: stimulus pushes timed expectations, a negedge monitor pops and compares.
module tb_sequenceur_jeu;

`ifdef SEQ_SCORE_EN
  localparam int SCORE1 = 1;
`else
  localparam int SCORE1 = 0;
`endif

  localparam int S_ETAT = 0, S_PULSE = 1, S_COL = 2, S_HG = 3, S_HC = 4, S_HD = 5, S_SCORE = 6;

  logic clk = 1'b0;
  logic reset, start, boutonTomber, boutonGauche, boutonDroite;
  logic PlusGauche, PlusCentre, PlusDroite, Aligne, Perdu;
  logic       pulse;
  logic [1:0] col;
  logic [2:0] hauteurGauche, hauteurCentre, hauteurDroite, etat;
  logic [7:0] score;

  sequenceur_jeu #(.TICK_DIV(16), .FAST_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .boutonTomber(boutonTomber),
    .boutonGauche(boutonGauche), .boutonDroite(boutonDroite),
    .PlusGauche(PlusGauche), .PlusCentre(PlusCentre), .PlusDroite(PlusDroite),
    .Aligne(Aligne), .Perdu(Perdu), .pulse(pulse), .col(col),
    .hauteurGauche(hauteurGauche), .hauteurCentre(hauteurCentre),
    .hauteurDroite(hauteurDroite), .etat(etat), .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sig);
    case (sig)
      S_ETAT:  return int'(etat);
      S_PULSE: return int'(pulse);
      S_COL:   return int'(col);
      S_HG:    return int'(hauteurGauche);
      S_HC:    return int'(hauteurCentre);
      S_HD:    return int'(hauteurDroite);
      default: return int'(score);
    endcase
  endfunction

  // Monitor: compares every expectation that is due in the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      a = actual(e.sig);
      checks++;
      if (a == e.val) passes++;
      else $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, a, e.val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sig, input int val, input string name);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(S_ETAT, 0, {tag, "_etat"});
    chk(S_PULSE, 0, {tag, "_pulse"});
    chk(S_COL, 1, {tag, "_col"});
    chk(S_HG, 0, {tag, "_hg"});
    chk(S_HC, 0, {tag, "_hc"});
    chk(S_HD, 0, {tag, "_hd"});
    chk(S_SCORE, 0, {tag, "_score"});
  endtask

  initial begin
    reset = 1; start = 0; boutonTomber = 0; boutonGauche = 0; boutonDroite = 0;
    PlusGauche = 0; PlusCentre = 0; PlusDroite = 0; Aligne = 0; Perdu = 0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 0;
    tick();
    chk(S_ETAT, 0, "idle_hold");

    // Start: IDLE -> SPAWN -> FALL, then slow ticks at period 16
    start = 1; tick(); chk(S_ETAT, 1, "spawn");
    start = 0; tick(); chk(S_ETAT, 2, "fall_entry");
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk(S_PULSE, (k == 16 || k == 32) ? 1 : 0, "pulse_slow");
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk(S_PULSE, 0, "pulse_count_to_10");
    end
    // Counter now at 10: fast mode fires on the very next edge, then period 4
    boutonTomber = 1; tick(); chk(S_PULSE, 1, "pulse_fast_switch");
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk(S_PULSE, (j % 4 == 0) ? 1 : 0, "pulse_fast");
    end
    boutonTomber = 0;

    // Column moves: three lefts clamp at 0, one right returns to 1
    for (int j = 0; j < 3; j++) begin
      boutonGauche = 1; tick(); chk(S_COL, 0, "col_left");
      boutonGauche = 0; tick();
    end
    boutonDroite = 1; tick(); chk(S_COL, 1, "col_right");
    boutonDroite = 0; tick();

    // Double landing with alignment -> CLEAR
    PlusCentre = 1; PlusDroite = 1; tick();
    chk(S_ETAT, 3, "land"); chk(S_HC, 1, "land_hc"); chk(S_HD, 1, "land_hd");
    chk(S_HG, 0, "land_hg"); chk(S_PULSE, 0, "land_pulse");
    PlusCentre = 0; PlusDroite = 0; Aligne = 1; tick();
    chk(S_ETAT, 4, "clear");
    Aligne = 0; tick();
    chk(S_ETAT, 1, "clear_spawn"); chk(S_HC, 0, "clear_hc"); chk(S_HD, 0, "clear_hd");
    chk(S_SCORE, SCORE1, "clear_score");
    tick(); chk(S_ETAT, 2, "refall");

    // Fill the centre column to 7 -> OVER at SPAWN
    for (int i = 1; i <= 7; i++) begin
      PlusCentre = 1; tick();
      chk(S_ETAT, 3, "fill_land"); chk(S_HC, i, "fill_hc");
      PlusCentre = 0; tick(); chk(S_ETAT, 1, "fill_spawn");
      tick(); chk(S_ETAT, (i == 7) ? 5 : 2, "fill_next");
    end
    tick(); chk(S_ETAT, 5, "over_hold"); chk(S_HC, 7, "over_hc_frozen");
    chk(S_SCORE, SCORE1, "over_score_frozen");
    start = 1; tick();
    chk(S_ETAT, 1, "restart_spawn"); chk(S_HC, 0, "restart_hc");
    chk(S_SCORE, 0, "restart_score"); chk(S_COL, 1, "restart_col");
    start = 0; tick(); chk(S_ETAT, 2, "restart_fall");

    // Left landing, then Perdu beats PlusGauche
    PlusGauche = 1; tick(); chk(S_HG, 1, "left_land");
    PlusGauche = 0; tick(); tick(); chk(S_ETAT, 2, "left_refall");
    Perdu = 1; PlusGauche = 1; tick();
    chk(S_ETAT, 5, "perdu_over"); chk(S_HG, 1, "perdu_hg_unchanged");
    Perdu = 0; PlusGauche = 0; tick();
    chk(S_ETAT, 5, "over_stay"); chk(S_HG, 1, "over_hg_frozen");
    reset = 1; tick();
    chk_reset_vals("reset_in_over");
    reset = 0; tick(); chk(S_ETAT, 0, "post_reset_idle");

    // Let the monitor drain, bounded
    for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      checks += q.size();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sequenceur_jeu.md
# sequenceur_jeu

Game-flow controller for the three-column falling-brick game. Sits between the player buttons and the gravity datapath (`Pesanteur`): it generates the gravity `pulse`, selects the active column, and owns the three column heights fed back to the datapath. It consumes the datapath's landing, alignment and loss flags. It sequences the game through spawn, fall, land, clear and game-over phases.

## Interface
Parameters:
- `TICK_DIV`, 10000: clock cycles between gravity pulses at normal speed (2..65535).
- `FAST_DIV`, 1000: clock cycles between pulses while `boutonTomber` is held (2..`TICK_DIV`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: start/restart request, rising-edge detected.
- `boutonTomber` in 1: level; selects `FAST_DIV` while high.
- `boutonGauche` in 1: rising edge moves the active column left.
- `boutonDroite` in 1: rising edge moves the active column right.
- `PlusGauche` in 1: one-cycle landing pulse from the datapath, left column.
- `PlusCentre` in 1: one-cycle landing pulse, centre column.
- `PlusDroite` in 1: one-cycle landing pulse, right column.
- `Aligne` in 1: alignment flag from the datapath, sampled in LAND.
- `Perdu` in 1: loss flag from the datapath.
- `pulse` out 1: gravity tick to the datapath, one cycle wide.
- `col` out 2: active column (0 = left, 1 = centre, 2 = right).
- `hauteurGauche` out 3: left column height.
- `hauteurCentre` out 3: centre column height.
- `hauteurDroite` out 3: right column height.
- `etat` out 3: current state code.
- `score` out 8: clear counter.

## Operation
State codes:
- IDLE=0: heights 0, `col`=1, `pulse`=0. A `start` rising edge goes to SPAWN.
- SPAWN=1: lasts one cycle. The tick counter is cleared.
  - Height of `col` = 7 → OVER.
  - Otherwise → FALL.
- FALL=2:
  - The tick counter runs and emits `pulse`.
  - Left/right edges move `col` by ±1, clamped to 0..2. Movement is ignored in every other state.
  - Any `Plus*` pulse increments each flagged height, saturating at 7, then → LAND.
  - `Perdu`=1 → OVER. `Perdu` has priority over `Plus*` in the same cycle; in that case heights are not incremented.
- LAND=3: lasts one cycle.
  - `Aligne`=1 → CLEAR.
  - Otherwise → SPAWN.
- CLEAR=4: lasts one cycle.
  - Each nonzero height is decremented by 1.
  - `score` increments, saturating at 255.
  - → SPAWN.
- OVER=5: heights and `score` are frozen. A `start` rising edge clears heights and `score`, sets `col`=1 and goes to SPAWN.

Edge detection:
- Each of `start`, `boutonGauche` and `boutonDroite` has one registered previous-value flop; edge = input & ~previous.
- An input held high across a state change produces no second edge.

Arithmetic:
- The tick counter is 16 bits.
- Divisor = `FAST_DIV` if `boutonTomber` else `TICK_DIV`.
- Terminal condition: `cnt >= divisor-1`. This makes a mid-count switch to fast mode fire on the next cycle when the counter is already past the fast limit.

## Timing
- On reset: `etat`=0, `pulse`=0, `col`=1, all heights 0, `score`=0, counter 0, edge flops 0. Reset asserted in any state takes effect at the next `clk` edge and overrides all other inputs.
- All outputs are registered; there is no combinational input→output path.
- `pulse`:
  - High for exactly one cycle, in the cycle after the counter meets terminal. The counter returns to 0 on that same edge.
  - Period = divisor cycles.
  - First pulse after entering FALL: divisor cycles after entry.
  - `pulse` is 0 outside FALL.
- Column move: `col` updates on the edge after the button's rising edge is sampled (1-cycle latency).
- Landing latency:
  - `Plus*` sampled at edge N in FALL → height updated and `etat`=LAND after N.
  - LAND → SPAWN/CLEAR after N+1.
  - Worst case back to FALL at N+3 (via CLEAR) or N+2 (direct).
- Simultaneous `Plus*` on several columns: all flagged heights increment in the same cycle, with a single LAND.

## Configuration
- `SEQ_SCORE_EN` defined: 8-bit saturating `score` register, incremented in CLEAR and cleared on restart.
- `SEQ_SCORE_EN` undefined: no score register; `score` is tied to 0. CLEAR still decrements heights.

## Test plan
- Reset held 3 cycles, then released; `start` pulsed → `etat` 0→1→2; with `TICK_DIV`=16, first `pulse` 16 cycles after FALL entry, then every 16 cycles.
- `boutonTomber` raised when the counter is at 10 with `FAST_DIV`=4 → `pulse` on the next cycle; subsequent period 4.
- `boutonGauche` pulsed 3 times in FALL from `col`=1 → `col` 0, stays 0; one `boutonDroite` pulse → `col` 1.
- `PlusCentre`+`PlusDroite` in the same cycle, `Aligne`=1 in LAND → heights C=1, R=1, then both 0 after CLEAR, `score`=1, `etat` returns to 2.
- `hauteurCentre` driven to 7 by landings with `col`=1 → SPAWN goes to OVER (`etat`=5); `start` edge → heights 0, `score` 0, `etat`=2 after SPAWN.
- `Perdu` and `PlusGauche` in the same cycle → `etat`=5, `hauteurGauche` unchanged; reset asserted in OVER → all outputs at reset values next cycle.
